// File: rtl/axi_lite_pkg.sv
// Shared types and response codes for the AXI4-Lite single-outstanding master.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // SLVERR and DECERR both carry bit 1 set
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one core request at a time into an AW/W/B or AR/R exchange.
// Optional abort watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int AXI_AWIDTH     = 32,
  parameter int AXI_DWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AXI_AWIDTH-1:0]   req_addr,
  input  logic [AXI_DWIDTH-1:0]   req_wdata,
  input  logic [AXI_DWIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [AXI_DWIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  state_e                  state, state_nxt;
  logic [AXI_AWIDTH-1:0]   addr_q;
  logic                    aw_fin, w_fin, b_hs, r_hs, timeout;

  assign req_ready  = (state == IDLE);
  assign AXI_BREADY = (state == WRESP);
  assign AXI_RREADY = (state == RDATA);
  assign AXI_AWADDR = addr_q;
  assign AXI_ARADDR = addr_q;

  // A channel counts as finished once its VALID has dropped or is handshaking now
  assign aw_fin = ~AXI_AWVALID | AXI_AWREADY;
  assign w_fin  = ~AXI_WVALID  | AXI_WREADY;
  assign b_hs   = (state == WRESP) & AXI_BVALID;
  assign r_hs   = (state == RDATA) & AXI_RVALID;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN)        to_cnt <= '0;
    else if (state == IDLE)  to_cnt <= '0;
    else                     to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state != IDLE) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)      state_nxt = req_we ? WRITE : RADDR;
      WRITE:   if (aw_fin & w_fin) state_nxt = WRESP;
      WRESP:   if (AXI_BVALID)     state_nxt = IDLE;
      RADDR:   if (AXI_ARREADY)    state_nxt = RDATA;
      RDATA:   if (AXI_RVALID)     state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      addr_q      <= '0;
      AXI_WDATA   <= '0;
      AXI_WSTRB   <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WVALID  <= 1'b0;
      AXI_ARVALID <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (req_valid && req_ready) begin
        addr_q      <= req_addr;
        AXI_WDATA   <= req_wdata;
        AXI_WSTRB   <= req_wstrb;
        AXI_AWVALID <= req_we;
        AXI_WVALID  <= req_we;
        AXI_ARVALID <= ~req_we;
      end
      if (AXI_AWVALID && AXI_AWREADY) AXI_AWVALID <= 1'b0;
      if (AXI_WVALID  && AXI_WREADY)  AXI_WVALID  <= 1'b0;
      if (AXI_ARVALID && AXI_ARREADY) AXI_ARVALID <= 1'b0;
      // A real response wins over a watchdog expiring in the same cycle
      if (b_hs) begin
        rsp_valid <= 1'b1;
        rsp_err   <= resp_is_err(AXI_BRESP);
      end else if (r_hs) begin
        rsp_valid <= 1'b1;
        rsp_err   <= resp_is_err(AXI_RRESP);
        rsp_rdata <= AXI_RDATA;
      end else if (timeout) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= 1'b1;
        rsp_rdata   <= '0;
        AXI_AWVALID <= 1'b0;
        AXI_WVALID  <= 1'b0;
        AXI_ARVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master; bench-side slave driven per cycle or by a simple auto-responder.
module tb_axi_lite_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic        auto_s;
  logic [31:0] auto_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; in auto mode the slave answers every VALID/READY
  task automatic tick();
    @(negedge clk);
    if (auto_s) begin
      awready = awvalid;
      wready  = wvalid;
      bvalid  = bready;
      bresp   = 2'b00;
      arready = arvalid;
      rvalid  = rready;
      rdata   = auto_rdata;
      rresp   = 2'b00;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) chk("rsp_wait_expired", 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, seen, ok;
    int cnt;
    rst_n = 1'b0; auto_s = 1'b0; auto_rdata = '0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_awvalid",   awvalid,   0);
    chk("rst_wvalid",    wvalid,    0);
    chk("rst_arvalid",   arvalid,   0);
    chk("rst_bready",    bready,    0);
    chk("rst_rready",    rready,    0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awaddr",    awaddr,    0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Write, AW and W accepted together, OKAY response
    issue(1'b1, 32'hF000_0000, 32'h1234_5678, 4'hF);
    chk("w1_awvalid", awvalid, 1);
    chk("w1_wvalid",  wvalid,  1);
    chk("w1_awaddr",  awaddr,  32'hF000_0000);
    chk("w1_wdata",   wdata,   32'h1234_5678);
    chk("w1_wstrb",   wstrb,   4'hF);
    chk("w1_busy",    req_ready, 0);
    tick();
    chk("w1_aw_held", awvalid, 1);
    chk("w1_w_held",  wvalid,  1);
    chk("w1_addr_held", awaddr, 32'hF000_0000);
    awready = 1; wready = 1;
    tick();
    chk("w1_aw_drop", awvalid, 0);
    chk("w1_w_drop",  wvalid,  0);
    chk("w1_bready",  bready,  1);
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
    tick();
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_rsp_err",   rsp_err,   0);
    chk("w1_bready_off", bready,   0);
    chk("w1_idle",      req_ready, 1);
    bvalid = 0;
    tick();
    chk("w1_rsp_pulse", rsp_valid, 0);

    // Read with ARREADY on the second cycle, SLVERR response
    issue(1'b0, 32'h0000_1000, '0, '0);
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr",  araddr,  32'h0000_1000);
    chk("r1_rready0", rready,  0);
    tick();
    chk("r1_ar_held", arvalid, 1);
    arready = 1;
    tick();
    chk("r1_ar_drop", arvalid, 0);
    chk("r1_rready",  rready,  1);
    arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
    tick();
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_rdata",     rsp_rdata, 32'hCAFE_F00D);
    chk("r1_err",       rsp_err,   1);
    chk("r1_rready_off", rready,   0);
    rvalid = 0; rresp = 0;
    tick();

    // Write with W accepted three cycles after AW
    issue(1'b1, 32'h0000_0004, 32'hAA55_AA55, 4'h3);
    awready = 1;
    tick();
    chk("w2_aw_drop",  awvalid, 0);
    chk("w2_w_held",   wvalid,  1);
    chk("w2_bready0a", bready,  0);
    awready = 0;
    tick();
    chk("w2_w_held2",  wvalid,  1);
    chk("w2_bready0b", bready,  0);
    tick();
    chk("w2_w_held3",  wvalid,  1);
    wready = 1;
    tick();
    chk("w2_w_drop",   wvalid,  0);
    chk("w2_bready",   bready,  1);
    wready = 0; bvalid = 1; bresp = 2'b10;
    tick();
    chk("w2_rsp_valid", rsp_valid, 1);
    chk("w2_err",       rsp_err,   1);
    chk("w2_rdata_hold", rsp_rdata, 32'hCAFE_F00D);
    bvalid = 0; bresp = 0;
    tick();

    // Reset while waiting for B
    issue(1'b1, 32'h0000_0008, 32'h0BAD_BEEF, 4'hF);
    awready = 1; wready = 1;
    tick();
    chk("rs_bready_pre", bready, 1);
    awready = 0; wready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_bready",    bready,    0);
    chk("rs_req_ready", req_ready, 1);
    chk("rs_awaddr",    awaddr,    0);
    chk("rs_wdata",     wdata,     0);
    chk("rs_rsp_err",   rsp_err,   0);
    chk("rs_rdata",     rsp_rdata, 0);
    bvalid = 1;
    seen = 1'b0;
    tick(); if (rsp_valid) seen = 1'b1;
    tick(); if (rsp_valid) seen = 1'b1;
    rst_n = 1'b1; bvalid = 0;
    tick(); if (rsp_valid) seen = 1'b1;
    tick(); if (rsp_valid) seen = 1'b1;
    chk("rs_no_rsp", seen, 0);
    auto_s = 1'b1;
    issue(1'b1, 32'h0000_000C, 32'h1111_2222, 4'hF);
    wait_rsp(20, got);
    chk("rs_after_err", rsp_err, 0);
    tick();

    // Back-to-back with req_valid held high
    auto_rdata = 32'h5A5A_1234;
    req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h3; req_wstrb = 4'h1;
    wait_rsp(20, got);
    chk("b2b_ready_at_rsp", req_ready, 1);
    req_we = 0; req_addr = 32'h20;
    tick();
    chk("b2b_arvalid", arvalid, 1);
    chk("b2b_araddr",  araddr,  32'h20);
    req_valid = 0;
    wait_rsp(20, got);
    chk("b2b_rdata", rsp_rdata, 32'h5A5A_1234);
    chk("b2b_err",   rsp_err,   0);
    tick();
    auto_s = 1'b0;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;

    // Read that the slave never accepts
    issue(1'b0, 32'h30, '0, '0);
`ifdef AXI_MASTER_TIMEOUT_EN
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (arvalid) cnt++;
      if (rsp_valid) begin got = 1'b1; break; end
      tick();
    end
    chk("to_rsp",    got,       1);
    chk("to_cycles", cnt,       16);
    chk("to_err",    rsp_err,   1);
    chk("to_rdata",  rsp_rdata, 0);
    chk("to_ar_off", arvalid,   0);
`else
    ok = 1'b1; cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      if (!arvalid || rsp_valid) ok = 1'b0;
      if (arvalid) cnt++;
      tick();
    end
    chk("hang_ar_held", ok, 1);
    chk("hang_cycles", cnt, 1100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("hang_recover", req_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
